// File: rtl/wb_stream_writer_if.sv
// Bus bundle for wb_stream_writer: Wishbone read master, Wishbone config
// slave, valid/ready stream source and interrupt line.
// Signal names keep the legacy port names so the direction suffixes still
// read from the DMA's point of view.
interface wb_stream_writer_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  // Wishbone master (memory fetch)
  logic [WB_AW-1:0] wbm_adr_o;
  logic [3:0]       wbm_sel_o;
  logic             wbm_we_o;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic [2:0]       wbm_cti_o;
  logic [1:0]       wbm_bte_o;
  logic [WB_DW-1:0] wbm_dat_i;
  logic             wbm_ack_i;
  logic             wbm_err_i;

  // Wishbone slave (configuration)
  logic [4:0]       wbs_adr_i;
  logic [31:0]      wbs_dat_i;
  logic [3:0]       wbs_sel_i;
  logic             wbs_we_i;
  logic             wbs_cyc_i;
  logic             wbs_stb_i;
  logic [31:0]      wbs_dat_o;
  logic             wbs_ack_o;

  // Stream source
  logic [WB_DW-1:0] stream_m_data_o;
  logic             stream_m_valid_o;
  logic             stream_m_ready_i;

  // Interrupt
  logic             irq_o;

  // DMA side
  modport master (
    output wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o,
    output stream_m_data_o, stream_m_valid_o,
    input  stream_m_ready_i,
    output irq_o
  );

  // Environment side (memory, CPU, sink)
  modport slave (
    input  wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o,
    input  stream_m_data_o, stream_m_valid_o,
    output stream_m_ready_i,
    input  irq_o
  );
endinterface

// File: rtl/wb_stream_writer.sv
// Memory-to-stream DMA. A Wishbone master fetches a word buffer with
// incrementing bursts into a FIFO; the FIFO drains onto a valid/ready
// stream. A small Wishbone slave holds the configuration and the irq flag.
module wb_stream_writer #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 7
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  wb_stream_writer_if.master bus
);

  localparam int unsigned      DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_W  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] ONE_W    = (FIFO_AW+1)'(1);
  localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(4);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // Configuration slave
  logic        ack_q,       ack_d;
  logic [31:0] rdat_q,      rdat_d;
  logic [31:0] start_adr_q, start_adr_d;
  logic [31:0] buf_size_q,  buf_size_d;
  logic [31:0] burst_len_q, burst_len_d;
  logic        irq_q,       irq_d;
  logic        err_q,       err_d;

  // Fetch engine
  logic [1:0]       state_q, state_d;
  logic [WB_AW-1:0] adr_q,   adr_d;
  logic [31:0]      rem_q,   rem_d;
  logic [FIFO_AW:0] beat_q,  beat_d;
  logic [FIFO_AW:0] burst_q, burst_d;

  // FIFO
  logic [WB_DW-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q,  cnt_d;

  logic             cfg_req;
  logic             cfg_wr;
  logic [2:0]       cfg_idx;
  logic             busy;
  logic             start_req;
  logic             irq_clr;
  logic             irq_set;
  logic             in_burst;
  logic             beat_ack;
  logic             beat_err;
  logic             push;
  logic             pop;
  logic             fifo_valid;
  logic [FIFO_AW:0] space;
  logic [FIFO_AW:0] burst_n;
  logic             unused_ok;

  assign unused_ok = ^{bus.wbs_sel_i, bus.wbs_adr_i[1:0]};

  assign cfg_req   = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
  assign cfg_wr    = cfg_req & bus.wbs_we_i;
  assign cfg_idx   = bus.wbs_adr_i[4:2];
  assign busy      = (state_q != S_IDLE);
  assign start_req = cfg_wr && (cfg_idx == 3'd0) && bus.wbs_dat_i[0] && !busy;
  assign irq_clr   = cfg_wr && (cfg_idx == 3'd0) && bus.wbs_dat_i[1];

  assign in_burst   = (state_q == S_BURST);
  assign beat_err   = in_burst && bus.wbm_err_i;
  assign beat_ack   = in_burst && bus.wbm_ack_i && !bus.wbm_err_i;
  assign push       = beat_ack;
  assign fifo_valid = (cnt_q != '0);
  assign pop        = fifo_valid && bus.stream_m_ready_i;

  assign space   = DEPTH_W - cnt_q;
  assign burst_n = (rem_q < 32'(burst_q)) ? rem_q[FIFO_AW:0] : burst_q;

  // Config register writes; BURST_LEN is stored already clamped to 1..DEPTH
  always_comb begin
    start_adr_d = start_adr_q;
    buf_size_d  = buf_size_q;
    burst_len_d = burst_len_q;
    if (cfg_wr) begin
      case (cfg_idx)
        3'd1: start_adr_d = {bus.wbs_dat_i[31:2], 2'b00};
        3'd2: buf_size_d  = bus.wbs_dat_i;
        3'd3: begin
          if (bus.wbs_dat_i == 32'd0)
            burst_len_d = 32'd1;
          else if (bus.wbs_dat_i > 32'(DEPTH))
            burst_len_d = 32'(DEPTH);
          else
            burst_len_d = bus.wbs_dat_i;
        end
        default: ;
      endcase
    end
  end

  // Config read mux and single-cycle ack
  always_comb begin
    ack_d  = cfg_req;
    rdat_d = '0;
    if (cfg_req) begin
      case (cfg_idx)
        3'd0:    rdat_d = {29'd0, err_q, irq_q, busy};
        3'd1:    rdat_d = start_adr_q;
        3'd2:    rdat_d = buf_size_q;
        3'd3:    rdat_d = burst_len_q;
        default: rdat_d = '0;
      endcase
    end
  end

  // Fetch FSM: wait for FIFO room, run one burst, repeat, then drain
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    err_d   = err_q;
    irq_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          err_d   = 1'b0;
          adr_d   = start_adr_q[WB_AW-1:0];
          rem_d   = buf_size_q;
          burst_d = (burst_len_q == 32'd0) ? ONE_W : burst_len_q[FIFO_AW:0];
          if (buf_size_q == 32'd0)
            irq_set = 1'b1;
          else
            state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (space >= burst_n) begin
          beat_d  = burst_n;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_err) begin
          err_d   = 1'b1;
          irq_set = 1'b1;
          state_d = S_IDLE;
        end else if (beat_ack) begin
          adr_d  = adr_q + ADR_STEP;
          rem_d  = rem_q - 32'd1;
          beat_d = beat_q - ONE_W;
          if (beat_q == ONE_W)
            state_d = (rem_q == 32'd1) ? S_DRAIN : S_WAIT;
        end
      end
      default: begin
        // Done once the last word is accepted (now or earlier)
        if (cnt_q == '0 || (cnt_q == ONE_W && pop)) begin
          irq_set = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // irq flag: a set in the same cycle as a clear write wins
  always_comb begin
    irq_d = irq_q;
    if (irq_clr)
      irq_d = 1'b0;
    if (irq_set)
      irq_d = 1'b1;
  end

  // FIFO pointer/count update; a bus error flushes everything queued
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (beat_err) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push)
        wptr_d = wptr_q + 1'b1;
      if (pop)
        rptr_d = rptr_q + 1'b1;
      if (push && !pop)
        cnt_d = cnt_q + ONE_W;
      else if (!push && pop)
        cnt_d = cnt_q - ONE_W;
    end
  end

  // Control and config state registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      start_adr_q <= '0;
      buf_size_q  <= '0;
      burst_len_q <= '0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
      state_q     <= S_IDLE;
      adr_q       <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      burst_q     <= '0;
    end else begin
      ack_q       <= ack_d;
      rdat_q      <= rdat_d;
      start_adr_q <= start_adr_d;
      buf_size_q  <= buf_size_d;
      burst_len_q <= burst_len_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
      state_q     <= state_d;
      adr_q       <= adr_d;
      rem_q       <= rem_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
    end
  end

  // FIFO pointers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // FIFO storage; contents are only observable while count is non-zero
  always_ff @(posedge wb_clk_i) begin
    if (push)
      mem_q[wptr_q] <= bus.wbm_dat_i;
  end

  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_sel_o = 4'hF;
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_cyc_o = in_burst;
  assign bus.wbm_stb_o = in_burst;
  assign bus.wbm_cti_o = !in_burst ? 3'b000 : (beat_q == ONE_W) ? 3'b111 : 3'b010;
  assign bus.wbm_bte_o = 2'b00;

  assign bus.wbs_dat_o = rdat_q;
  assign bus.wbs_ack_o = ack_q;

  assign bus.stream_m_valid_o = fifo_valid;
  assign bus.stream_m_data_o  = fifo_valid ? mem_q[rptr_q] : '0;

  assign bus.irq_o = irq_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Self-checking bench for wb_stream_writer: memory model with random wait
// states and address/cti checks, a stream sink fed by an expected-data queue,
// and a CPU-side config task sequence.
module tb_wb_stream_writer;

  localparam int FAW   = 3;
  localparam int DEPTH = 1 << FAW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stream_writer_if #(.WB_AW(32), .WB_DW(32)) bus_if ();

  wb_stream_writer #(
    .WB_AW   (32),
    .WB_DW   (32),
    .FIFO_AW (FAW)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  // memory model state
  bit          mem_wait_en = 1'b1;
  int          err_beat = 0;
  int          beat_no = 0;
  int          ack_cnt = 0;
  int          cyc_cnt = 0;
  logic [31:0] m_exp_adr = '0;
  int          m_rem = 0;
  int          m_bl = 1;
  int          m_pos = 0;
  int          m_n = 1;
  bit          chk_cyc_drop = 1'b0;

  // sink state
  bit ready_en = 1'b0;
  bit chk_irq_last = 1'b0;
  bit irq_pending = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Memory: word[i] = i at byte address 4*i; checks address and cti per beat
  always @(negedge clk) begin
    if (chk_cyc_drop) begin
      check_eq("cyc_drop", 32'(bus_if.wbm_cyc_o), 32'd0);
      chk_cyc_drop = 1'b0;
    end
    bus_if.wbm_ack_i = 1'b0;
    bus_if.wbm_err_i = 1'b0;
    if (rst_n && bus_if.wbm_cyc_o)
      cyc_cnt++;
    if (rst_n && bus_if.wbm_cyc_o && bus_if.wbm_stb_o &&
        (!mem_wait_en || $urandom_range(0, 3) != 0)) begin
      beat_no++;
      if (beat_no == err_beat) begin
        bus_if.wbm_err_i = 1'b1;
        err_beat = 0;
        chk_cyc_drop = 1'b1;
      end else begin
        bus_if.wbm_ack_i = 1'b1;
        bus_if.wbm_dat_i = bus_if.wbm_adr_o >> 2;
        ack_cnt++;
        if (m_pos == 0)
          m_n = (m_rem < m_bl) ? m_rem : m_bl;
        check_eq("wbm_adr", bus_if.wbm_adr_o, m_exp_adr);
        check_eq("wbm_cti", 32'(bus_if.wbm_cti_o), (m_pos == m_n - 1) ? 32'd7 : 32'd2);
        m_exp_adr = m_exp_adr + 32'd4;
        m_rem--;
        m_pos++;
        if (m_pos == m_n) begin
          m_pos = 0;
          chk_cyc_drop = 1'b1;
        end
      end
    end
  end

  // Sink: drives ready, compares accepted words and stalled data
  always @(negedge clk) begin
    if (irq_pending) begin
      check_eq("irq_after_last", 32'(bus_if.irq_o), 32'd1);
      irq_pending = 1'b0;
    end
    bus_if.stream_m_ready_i = ready_en;
    if (rst_n && bus_if.stream_m_valid_o) begin
      if (bus_if.stream_m_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("stream_extra", 32'(bus_if.stream_m_valid_o), 32'd0);
        end else begin
          if (chk_irq_last && exp_q.size() == 1) begin
            check_eq("irq_before_last", 32'(bus_if.irq_o), 32'd0);
            irq_pending = 1'b1;
          end
          check_eq("stream_data", bus_if.stream_m_data_o, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        check_eq("stream_hold", bus_if.stream_m_data_o, exp_q[0]);
      end
    end
  end

  task automatic cfg_access(input logic [4:0] adr, input logic we,
                            input logic [31:0] wdat, output logic [31:0] rdat);
    int n;
    n = 0;
    @(negedge clk);
    bus_if.wbs_adr_i = adr;
    bus_if.wbs_we_i  = we;
    bus_if.wbs_dat_i = wdat;
    bus_if.wbs_sel_i = 4'hF;
    bus_if.wbs_cyc_i = 1'b1;
    bus_if.wbs_stb_i = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_if.wbs_ack_o && n < 20);
    check_eq("wbs_ack", 32'(bus_if.wbs_ack_o), 32'd1);
    rdat = bus_if.wbs_dat_o;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;
    bus_if.wbs_we_i  = 1'b0;
    @(negedge clk);
    check_eq("wbs_single_ack", 32'(bus_if.wbs_ack_o), 32'd0);
  endtask

  task automatic cfg_write(input logic [4:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    cfg_access(adr, 1'b1, dat, dummy);
  endtask

  task automatic cfg_read(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    cfg_access(adr, 1'b0, '0, rd);
    check_eq(tag, rd, exp);
  endtask

  // Program START/BUF_SIZE/BURST_LEN, arm the memory model, queue expected words
  task automatic setup_xfer(input logic [31:0] sa, input int size, input int bl,
                            input int bl_eff, input bit queue_words);
    cfg_write(5'h04, sa);
    cfg_write(5'h08, 32'(size));
    cfg_write(5'h0C, 32'(bl));
    m_exp_adr = sa;
    m_rem     = size;
    m_bl      = bl_eff;
    m_pos     = 0;
    beat_no   = 0;
    if (queue_words)
      for (int i = 0; i < size; i++)
        exp_q.push_back((sa >> 2) + 32'(i));
  endtask

  task automatic wait_irq(input int max_cyc);
    int n;
    n = 0;
    while (!bus_if.irq_o && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("irq_wait", 32'(bus_if.irq_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ack;
    int base_cyc;
    int n;

    bus_if.wbs_adr_i = '0;
    bus_if.wbs_dat_i = '0;
    bus_if.wbs_sel_i = '0;
    bus_if.wbs_we_i  = 1'b0;
    bus_if.wbs_cyc_i = 1'b0;
    bus_if.wbs_stb_i = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(bus_if.wbm_stb_o), 32'd0);
    check_eq("rst_sel", 32'(bus_if.wbm_sel_o), 32'hF);
    check_eq("rst_we", 32'(bus_if.wbm_we_o), 32'd0);
    check_eq("rst_valid", 32'(bus_if.stream_m_valid_o), 32'd0);
    check_eq("rst_irq", 32'(bus_if.irq_o), 32'd0);
    check_eq("rst_wbs_ack", 32'(bus_if.wbs_ack_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Registers
    cfg_write(5'h04, 32'h0000_1003);
    cfg_read("start_adr_align", 5'h04, 32'h0000_1000);
    cfg_write(5'h0C, 32'd0);
    cfg_read("burst_len_zero", 5'h0C, 32'd1);
    cfg_write(5'h0C, 32'd100);
    cfg_read("burst_len_clamp", 5'h0C, 32'(DEPTH));
    cfg_write(5'h0C, 32'd5);
    cfg_read("burst_len_plain", 5'h0C, 32'd5);
    cfg_write(5'h08, 32'h55);
    cfg_read("buf_size", 5'h08, 32'h55);
    cfg_write(5'h14, 32'hFFFF_FFFF);
    cfg_read("undef_adr5", 5'h14, 32'd0);
    cfg_read("undef_adr7", 5'h1C, 32'd0);
    cfg_read("stat_idle", 5'h00, 32'd0);

    // Basic transfer: 16 words, bursts of 8, sink always ready
    ready_en = 1'b1;
    base_ack = ack_cnt;
    setup_xfer(32'h0, 16, 8, 8, 1'b1);
    chk_irq_last = 1'b1;
    cfg_write(5'h00, 32'h1);
    wait_irq(2000);
    @(negedge clk);
    chk_irq_last = 1'b0;
    check_eq("basic_drained", 32'(exp_q.size()), 32'd0);
    check_eq("basic_beats", 32'(ack_cnt - base_ack), 32'd16);
    cfg_read("basic_stat", 5'h00, 32'h2);

    // Backpressure: 10 words, bursts of 4, sink stalled; start while busy ignored
    cfg_write(5'h00, 32'h2);
    check_eq("irq_cleared", 32'(bus_if.irq_o), 32'd0);
    ready_en = 1'b0;
    base_ack = ack_cnt;
    setup_xfer(32'h100, 10, 4, 4, 1'b1);
    cfg_write(5'h00, 32'h1);
    repeat (80) @(negedge clk);
    check_eq("bp_fifo_full_beats", 32'(ack_cnt - base_ack), 32'(DEPTH));
    check_eq("bp_cyc_idle", 32'(bus_if.wbm_cyc_o), 32'd0);
    check_eq("bp_valid", 32'(bus_if.stream_m_valid_o), 32'd1);
    cfg_read("bp_stat_busy", 5'h00, 32'h1);
    cfg_write(5'h04, 32'h2000);
    cfg_write(5'h00, 32'h1);
    cfg_read("bp_stat_still_busy", 5'h00, 32'h1);
    ready_en = 1'b1;
    wait_irq(2000);
    @(negedge clk);
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
    check_eq("bp_beats", 32'(ack_cnt - base_ack), 32'd10);

    // Bus error on beat 3 of the first burst
    cfg_write(5'h00, 32'h2);
    ready_en = 1'b0;
    setup_xfer(32'h0, 16, 8, 8, 1'b0);
    err_beat = 3;
    cfg_write(5'h00, 32'h1);
    wait_irq(2000);
    @(negedge clk);
    cfg_read("err_stat", 5'h00, 32'h6);
    check_eq("err_valid", 32'(bus_if.stream_m_valid_o), 32'd0);
    cfg_write(5'h00, 32'h2);
    cfg_read("err_stat_cleared_irq", 5'h00, 32'h4);
    ready_en = 1'b1;
    setup_xfer(32'h40, 4, 4, 4, 1'b1);
    cfg_write(5'h00, 32'h1);
    wait_irq(2000);
    @(negedge clk);
    check_eq("restart_drained", 32'(exp_q.size()), 32'd0);
    cfg_read("restart_stat", 5'h00, 32'h2);

    // BUF_SIZE = 0: no bus cycle, irq right after the start write
    cfg_write(5'h00, 32'h2);
    check_eq("zero_irq_before", 32'(bus_if.irq_o), 32'd0);
    cfg_write(5'h08, 32'd0);
    base_ack = ack_cnt;
    base_cyc = cyc_cnt;
    cfg_write(5'h00, 32'h1);
    check_eq("zero_irq", 32'(bus_if.irq_o), 32'd1);
    cfg_read("zero_stat", 5'h00, 32'h2);
    repeat (5) @(negedge clk);
    check_eq("zero_no_cyc", 32'(cyc_cnt - base_cyc), 32'd0);
    check_eq("zero_no_ack", 32'(ack_cnt - base_ack), 32'd0);

    // Clear and set in the same cycle: set wins
    cfg_write(5'h00, 32'h2);
    check_eq("clr_irq", 32'(bus_if.irq_o), 32'd0);
    cfg_write(5'h00, 32'h3);
    check_eq("set_wins", 32'(bus_if.irq_o), 32'd1);

    // Asynchronous reset mid-burst (irq still set from above)
    mem_wait_en = 1'b0;
    setup_xfer(32'h0, 64, 8, 8, 1'b1);
    cfg_write(5'h00, 32'h1);
    n = 0;
    while (!(bus_if.wbm_cyc_o && bus_if.stream_m_valid_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_mid_reached", 32'(bus_if.wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_cyc", 32'(bus_if.wbm_cyc_o), 32'd0);
    check_eq("rst_mid_stb", 32'(bus_if.wbm_stb_o), 32'd0);
    check_eq("rst_mid_valid", 32'(bus_if.stream_m_valid_o), 32'd0);
    check_eq("rst_mid_irq", 32'(bus_if.irq_o), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_read("rst_ctrl", 5'h00, 32'd0);
    cfg_read("rst_start_adr", 5'h04, 32'd0);
    cfg_read("rst_buf_size", 5'h08, 32'd0);
    cfg_read("rst_burst_len", 5'h0C, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stream_writer.md
Name: wb_stream_writer

Overview:
- Memory-to-stream DMA; mirror of the capture-path stream reader.
- Wishbone master fetches a word buffer from RAM (HyperRAM or SRAM) using incrementing bursts.
- Fetched words go through an internal FIFO and out on a valid/ready stream, e.g. toward an SD or video sink.
- The CPU configures the block through a small Wishbone slave and gets an IRQ when the last word leaves the stream port.

Parameters:
WB_AW, 32, master address width
WB_DW, 32, data width (fixed 32; sel is 4 bits)
FIFO_AW, 7, FIFO depth 2^FIFO_AW words; maximum burst length

Ports:
wb_clk_i  in  1  system clock
wb_rst_n_i  in  1  reset, asynchronous, active-low
wbm_adr_o  out  WB_AW  master byte address
wbm_sel_o  out  4  constant 4'hF
wbm_we_o  out  1  constant 0
wbm_cyc_o, wbm_stb_o  out  1  master cycle/strobe
wbm_cti_o  out  3  3'b010 incrementing, 3'b111 end-of-burst
wbm_bte_o  out  2  constant 2'b00
wbm_dat_i  in  WB_DW  read data
wbm_ack_i, wbm_err_i  in  1  slave ack/error
wbs_adr_i  in  5  config address
wbs_dat_i  in  32  config write data
wbs_sel_i  in  4  ignored (full-word writes only)
wbs_we_i, wbs_cyc_i, wbs_stb_i  in  1  config bus
wbs_dat_o  out  32  config read data
wbs_ack_o  out  1  config ack
stream_m_data_o  out  32  stream data
stream_m_valid_o  out  1  FIFO not empty
stream_m_ready_i  in  1  sink ready
irq_o  out  1  level, = irq flag

Behaviour:
- Reset values: all outputs 0 except the constants; registers 0; FIFO empty; FSM in IDLE.
- Config slave: wbs_ack_o is asserted one cycle after cyc&stb and lasts one cycle; it is deasserted for at least one cycle between accesses. Registers, decoded on wbs_adr_i[4:2]:
  - 0 CTRL/STAT. Write: bit0=1 starts a transfer (ignored while busy); bit1=1 clears the irq flag. Read: bit0 busy, bit1 irq, bit2 err.
  - 1 START_ADR: byte address; bits[1:0] are forced to 0.
  - 2 BUF_SIZE: transfer length in words.
  - 3 BURST_LEN: words per burst. 0 means 1; values above 2^FIFO_AW are clamped to 2^FIFO_AW.
  - Any other address reads 0; writes to it are ignored.
- Start: START_ADR, BUF_SIZE and BURST_LEN are copied into working registers. Later register writes affect only the next transfer. busy=1 and err=0.
- BUF_SIZE=0: busy stays 0; the irq flag is set on the cycle after the start write.
- Master FSM:
  - IDLE -> WAIT_SPACE on start.
  - WAIT_SPACE -> BURST when FIFO free space >= n, where n = min(BURST_LEN, remaining). Beat counter loads n.
  - BURST: cyc=stb=1; adr = current address; cti=3'b111 on the last beat, else 3'b010.
    - On each ack: push wbm_dat_i into the FIFO, address += 4, remaining -= 1, beat counter -= 1.
    - After the last beat, cyc/stb drop the following cycle.
    - If remaining == 0, go to DRAIN; otherwise go to WAIT_SPACE.
  - DRAIN -> IDLE once the FIFO is empty and the last word has been accepted. Same cycle: busy=0 and the irq flag is set.
  - err in BURST: ack/err in that cycle is discarded. cyc drops next cycle; err=1; the FIFO is flushed; busy=0; the irq flag is set; go to IDLE.
- Address wrap-around beyond 2^WB_AW is modulo; no error is raised.
- FIFO never overflows: the space check happens before each burst. There is no underflow: valid is low when empty.
- Stream port:
  - Beat transfers on valid&ready.
  - stream_m_data_o holds stable while valid && !ready.
  - Push and pop in the same cycle leave the FIFO count unchanged.
  - First word appears on stream_m_valid_o at the earliest one cycle after its ack.
- Simultaneous irq set and irq-clear write: set wins.
- Asynchronous reset mid-burst:
  - cyc/stb drop immediately.
  - FIFO is emptied.
  - The current transfer is lost.

Test Plan:
- Registers: write START_ADR=0x1003 and BURST_LEN=0 -> reads return 0x1000 and 1. Undefined address reads 0. Each access gets exactly one ack.
- Basic transfer: START=0x0, BUF_SIZE=16, BURST_LEN=8, memory model word[i]=i, ready=1:
  - two bursts, each with 7x cti 010 then 111;
  - addresses 0x00..0x3C;
  - stream emits 0..15 in order;
  - irq rises after the 16th accept; busy goes 0.
- Partial last burst with backpressure: BUF_SIZE=10, BURST_LEN=4, ready held 0:
  - bursts of 4, 4, 2, fetched as FIFO space allows (FIFO_AW=2 build: one burst at a time);
  - no FIFO overflow;
  - data stable while stalled;
  - after releasing ready, 10 words arrive in order.
- Error: wbm_err_i on beat 3 of the first burst:
  - cyc drops next cycle;
  - STAT reads err=1, irq=1, busy=0;
  - stream_m_valid_o is 0;
  - a fresh start succeeds.
- Edge controls:
  - BUF_SIZE=0 start -> no bus cycle, irq next cycle.
  - Start while busy is ignored.
  - irq clear in the same cycle as irq set leaves irq=1.
- Reset: assert wb_rst_n_i mid-burst -> cyc/stb/valid/irq go 0 immediately; all registers read 0 after release.
